// File: rtl/mmu_io_pkg.sv
// Shared offsets and bit positions for the I/O window register bank.
package mmu_io_pkg;

    localparam logic [31:0] IO_BASE = 32'h8000_0000;

    localparam logic [7:0] IO_GPIO_OUT  = 8'h00;
    localparam logic [7:0] IO_GPIO_IN   = 8'h04;
    localparam logic [7:0] IO_CYCLE     = 8'h08;
    localparam logic [7:0] IO_TIMER_CMP = 8'h0C;
    localparam logic [7:0] IO_TX_DATA   = 8'h10;
    localparam logic [7:0] IO_STATUS    = 8'h14;
    localparam logic [7:0] IO_CTRL      = 8'h18;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_TIMER     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_TIMER_EN  = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_CLR_TIMER = 8;
    localparam int CTRL_CLR_OVF   = 9;

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO feeding the TX sink; push is already qualified by the caller.
module io_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int LOG   = 3
) (
    input  logic           clk,
    input  logic           resetb,
    input  logic           push,
    input  logic           pop,
    input  logic [7:0]     din,
    output logic [7:0]     head,
    output logic           full,
    output logic           empty,
    output logic [LOG:0]   count
);

    logic [7:0]     mem [DEPTH];
    logic [LOG-1:0] wr_ptr;
    logic [LOG-1:0] rd_ptr;

    // Storage carries no reset; empty pointers make stale bytes invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (LOG+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/io_port_bank.sv
// I/O window device: GPIO, cycle counter with compare IRQ, and a TX byte FIFO.
module io_port_bank
    import mmu_io_pkg::*;
#(
    parameter int          GPIO_W     = 8,
    parameter logic [31:0] GPIO_RESET = 32'h0,
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_LOG   = 3
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [7:0]        io_addr,
    input  logic              io_en,
    input  logic              io_we,
    input  logic [31:0]       io_data_write,
    output logic [31:0]       io_data_read,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              irq
);

    logic [7:0]        reg_addr;
    logic              wr;
    logic              rd;
    logic [GPIO_W-1:0] gpio_sync1;
    logic [GPIO_W-1:0] gpio_sync2;
    logic [31:0]       cycle;
    logic [31:0]       timer_cmp;
    logic              timer_en;
    logic              irq_en;
    logic              timer_flag;
    logic              overflow;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_LOG:0] fifo_count;
    logic              tx_wr;
    logic              fifo_pop;
    logic              fifo_push;
    logic              timer_hit;
    logic              ctrl_wr;
    logic              unused_addr_lsbs;

    assign reg_addr         = {io_addr[7:2], 2'b00};
    assign unused_addr_lsbs = ^io_addr[1:0];
    assign wr               = io_en && io_we;
    assign rd               = io_en && !io_we;
    assign tx_wr            = wr && (reg_addr == IO_TX_DATA);
    assign ctrl_wr          = wr && (reg_addr == IO_CTRL);

    assign fifo_pop  = tx_valid && tx_ready;
    assign fifo_push = tx_wr && (!fifo_full || fifo_pop);
    assign timer_hit = timer_en && (cycle == timer_cmp);

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LOG   (FIFO_LOG)
    ) u_tx_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (io_data_write[7:0]),
        .head   (tx_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign tx_valid = !fifo_empty;
    assign irq      = timer_flag && irq_en;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
            gpio_out   <= GPIO_RESET[GPIO_W-1:0];
            cycle      <= '0;
            timer_cmp  <= '0;
            timer_en   <= 1'b0;
            irq_en     <= 1'b0;
            timer_flag <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            cycle      <= cycle + 32'd1;

            if (wr && reg_addr == IO_GPIO_OUT) begin
                gpio_out <= io_data_write[GPIO_W-1:0];
            end
            if (wr && reg_addr == IO_TIMER_CMP) begin
                timer_cmp <= io_data_write;
            end
            if (ctrl_wr) begin
                timer_en <= io_data_write[CTRL_TIMER_EN];
                irq_en   <= io_data_write[CTRL_IRQ_EN];
            end

            // A fresh event in the same cycle as a clear must not be lost.
            if (timer_hit) begin
                timer_flag <= 1'b1;
            end else if (ctrl_wr && io_data_write[CTRL_CLR_TIMER]) begin
                timer_flag <= 1'b0;
            end

            if (tx_wr && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && io_data_write[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        io_data_read = 32'h0;
        if (rd) begin
            case (reg_addr)
                IO_GPIO_OUT:  io_data_read = 32'(gpio_out);
                IO_GPIO_IN:   io_data_read = 32'(gpio_sync2);
                IO_CYCLE:     io_data_read = cycle;
                IO_TIMER_CMP: io_data_read = timer_cmp;
                IO_STATUS: begin
                    io_data_read[ST_FULL]  = fifo_full;
                    io_data_read[ST_EMPTY] = fifo_empty;
                    io_data_read[ST_TIMER] = timer_flag;
                    io_data_read[ST_OVF]   = overflow;
                    io_data_read[ST_COUNT_LSB +: FIFO_LOG+1] = fifo_count;
                end
                IO_CTRL: begin
                    io_data_read[CTRL_TIMER_EN] = timer_en;
                    io_data_read[CTRL_IRQ_EN]   = irq_en;
                end
                default: io_data_read = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: GPIO, timer/IRQ, TX FIFO fill/drain and reset.
module tb_io_port_bank;
    import mmu_io_pkg::*;

    logic        clk = 1'b0;
    logic        resetb;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    io_port_bank dut (
        .clk           (clk),
        .resetb        (resetb),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [31:0] d);
        io_addr       = a;
        io_data_write = d;
        io_we         = 1'b1;
        io_en         = 1'b1;
        @(posedge clk);
        #1;
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [31:0] d);
        io_addr = a;
        io_we   = 1'b0;
        io_en   = 1'b1;
        #1;
        d     = io_data_read;
        io_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rv;
        logic [31:0] c0, c1, c2, cmp;
        logic [7:0]  drain_exp [8];
        bit          found;

        resetb        = 1'b0;
        io_addr       = 8'h0;
        io_en         = 1'b0;
        io_we         = 1'b0;
        io_data_write = 32'h0;
        gpio_in       = 8'h0;
        tx_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_gpio_out", 32'(gpio_out), 32'h0);
        check_val("rst_tx_valid", 32'(tx_valid), 32'h0);
        check_val("rst_irq", 32'(irq), 32'h0);
        resetb = 1'b1;
        tick();
        io_read(IO_STATUS, rv);
        check_val("rst_status", rv, 32'h2);

        // GPIO write/read and input synchroniser lag
        io_write(IO_GPIO_OUT, 32'h0000_00A5);
        check_val("gpio_out_pin", 32'(gpio_out), 32'hA5);
        io_read(IO_GPIO_OUT, rv);
        check_val("gpio_out_rd", rv, 32'h0000_00A5);
        gpio_in = 8'h3C;
        tick();
        io_read(IO_GPIO_IN, rv);
        check_val("gpio_in_lag1", rv, 32'h0);
        tick();
        io_read(IO_GPIO_IN, rv);
        check_val("gpio_in_lag2", rv, 32'h3C);

        // cycle counter
        io_read(IO_CYCLE, c0);
        tick();
        io_read(IO_CYCLE, c1);
        check_val("cycle_inc", c1, c0 + 32'd1);
        io_write(IO_CYCLE, 32'h0);
        io_read(IO_CYCLE, c2);
        check_val("cycle_wr_ignored", c2, c1 + 32'd1);

        // timer compare and IRQ
        cmp = c2 + 32'd20;
        io_write(IO_TIMER_CMP, cmp);
        io_write(IO_CTRL, 32'h3);
        io_read(IO_TIMER_CMP, rv);
        check_val("cmp_rd", rv, cmp);
        io_read(IO_CTRL, rv);
        check_val("ctrl_rd", rv, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            io_read(IO_CYCLE, rv);
            if (rv == cmp) begin
                found = 1'b1;
                check_val("irq_at_match", 32'(irq), 32'h0);
                tick();
                check_val("irq_after_match", 32'(irq), 32'h1);
            end else begin
                tick();
            end
        end
        check_val("timer_match_seen", 32'(found), 32'h1);
        io_read(IO_STATUS, rv);
        check_val("status_flag", rv, 32'h6);
        io_write(IO_CTRL, 32'h103);
        check_val("irq_cleared", 32'(irq), 32'h0);
        io_read(IO_STATUS, rv);
        check_val("status_flag_clr", rv, 32'h2);
        io_read(IO_CTRL, rv);
        check_val("ctrl_clr_bits_rd0", rv, 32'h3);

        // fill FIFO past capacity with sink stalled
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            io_write(IO_TX_DATA, {24'hDEADBE, 8'(i)});
        end
        io_read(IO_STATUS, rv);
        check_val("status_full_ovf", rv, 32'h0000_0809);
        check_val("fill_tx_valid", 32'(tx_valid), 32'h1);
        check_val("fill_head", 32'(tx_data), 32'h01);
        io_read(IO_TX_DATA, rv);
        check_val("tx_data_rd0", rv, 32'h0);
        io_write(IO_CTRL, 32'h203);
        io_read(IO_STATUS, rv);
        check_val("status_ovf_clr", rv, 32'h0000_0801);

        // push into a full FIFO while the sink pops
        tx_ready = 1'b1;
        io_write(IO_TX_DATA, 32'h0000_0055);
        io_read(IO_STATUS, rv);
        check_val("push_pop_full", rv, 32'h0000_0801);

        // drain: one byte per cycle; 0x09 was dropped, 0x55 is last
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("drain_valid%0d", i), 32'(tx_valid), 32'h1);
            check_val($sformatf("drain_data%0d", i), 32'(tx_data), 32'(drain_exp[i]));
            tick();
        end
        check_val("drain_done_valid", 32'(tx_valid), 32'h0);
        io_read(IO_STATUS, rv);
        check_val("drain_status", rv, 32'h2);

        // reset in the middle of a drain with IRQ pending
        tx_ready = 1'b0;
        io_read(IO_CYCLE, c0);
        io_write(IO_TIMER_CMP, c0 + 32'd4);
        io_write(IO_GPIO_OUT, 32'hFF);
        io_write(IO_TX_DATA, 32'h11);
        io_write(IO_TX_DATA, 32'h22);
        io_write(IO_TX_DATA, 32'h33);
        check_val("irq_pre_reset", 32'(irq), 32'h1);
        tx_ready = 1'b1;
        tick();
        check_val("mid_drain_head", 32'(tx_data), 32'h22);
        resetb = 1'b0;
        #1;
        check_val("async_rst_gpio", 32'(gpio_out), 32'h0);
        check_val("async_rst_valid", 32'(tx_valid), 32'h0);
        check_val("async_rst_irq", 32'(irq), 32'h0);
        #3;
        resetb = 1'b1;
        tick();
        io_read(8'h20, rv);
        check_val("unmapped_rd", rv, 32'h0);
        io_read(IO_STATUS, rv);
        check_val("post_rst_status", rv, 32'h2);
        io_read(IO_CTRL, rv);
        check_val("post_rst_ctrl", rv, 32'h0);
        io_write(IO_GPIO_OUT, 32'h5A);
        io_addr = IO_GPIO_OUT;
        io_en   = 1'b0;
        #1;
        check_val("rd_no_en", io_data_read, 32'h0);
        io_read(IO_GPIO_OUT, rv);
        check_val("gpio_after_rst", rv, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
